// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - tiny16 fetch/decode/execute control sequencer
// Drives register-file controls, memory request handshake and input-mux select.
module control_sequencer #(
  parameter logic [3:0] PC_IDX = 4'd1,
  parameter logic [3:0] SP_IDX = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_addr_sel,
  output logic [1:0]  in_sel,
  output logic [3:0]  alu_op,
  output logic [3:0]  src_sel,
  output logic [3:0]  dst_sel,
  output logic        in_en,
  output logic        up_en,
  output logic        lo_en,
  output logic        pc_inc,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        out_en,
  output logic        halted,
  output logic        illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_LDL   = 4'h2;
  localparam logic [3:0] OP_LDH   = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_PUSH  = 4'h6;
  localparam logic [3:0] OP_POP   = 4'h7;
  localparam logic [3:0] OP_ALU   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_SRC = 2'd1;
  localparam logic [1:0] ADDR_DST = 2'd2;
  localparam logic [1:0] ADDR_SP  = 2'd3;

  localparam logic [1:0] IN_SRC  = 2'd0;
  localparam logic [1:0] IN_IMM  = 2'd1;
  localparam logic [1:0] IN_MEM  = 2'd2;
  localparam logic [1:0] IN_ALU  = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [3:0] op_f, d_f, s_f;
  assign op_f = ir_q[15:12];
  assign d_f  = ir_q[11:8];
  assign s_f  = ir_q[7:4];

  // The SP register is addressed implicitly through mem_addr_sel and sp_inc/sp_dec.
  logic unused_sp_idx;
  assign unused_sp_idx = ^SP_IDX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_PC;
    in_sel       = IN_SRC;
    alu_op       = 4'h0;
    src_sel      = 4'h0;
    dst_sel      = 4'h0;
    in_en        = 1'b0;
    up_en        = 1'b0;
    lo_en        = 1'b0;
    pc_inc       = 1'b0;
    sp_inc       = 1'b0;
    sp_dec       = 1'b0;
    out_en       = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_PC;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        src_sel = s_f;
        dst_sel = d_f;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        src_sel = s_f;
        dst_sel = d_f;
        state_d = S_FETCH;
        case (op_f)
          OP_NOP: ;
          OP_MOV: begin
            in_sel = IN_SRC;
            in_en  = 1'b1;
          end
          OP_LDL: begin
            in_sel = IN_IMM;
            lo_en  = 1'b1;
          end
          OP_LDH: begin
            in_sel = IN_IMM;
            up_en  = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_PUSH: state_d = S_MEM;
          OP_POP: begin
            // Pre-increment so the MEM read sees the already-advanced SP.
            sp_inc  = 1'b1;
            state_d = S_MEM;
          end
          OP_ALU: begin
            in_sel = IN_ALU;
            in_en  = 1'b1;
            alu_op = ir_q[3:0];
          end
          OP_JMP: begin
            dst_sel = PC_IDX;
            in_sel  = IN_SRC;
            in_en   = 1'b1;
          end
          OP_HALT: state_d = S_HALT;
          default: illegal = 1'b1;
        endcase
      end

      S_MEM: begin
        src_sel = s_f;
        dst_sel = d_f;
        mem_req = 1'b1;
        case (op_f)
          OP_LOAD: begin
            mem_addr_sel = ADDR_SRC;
            if (mem_ack) begin
              in_sel = IN_MEM;
              in_en  = 1'b1;
            end
          end
          OP_STORE: begin
            mem_addr_sel = ADDR_DST;
            mem_we       = 1'b1;
            out_en       = 1'b1;
          end
          OP_PUSH: begin
            mem_addr_sel = ADDR_SP;
            mem_we       = 1'b1;
            out_en       = 1'b1;
            if (mem_ack) sp_dec = 1'b1;
          end
          OP_POP: begin
            mem_addr_sel = ADDR_SP;
            if (mem_ack) begin
              in_sel = IN_MEM;
              in_en  = 1'b1;
            end
          end
          default: ;
        endcase
        if (mem_ack) state_d = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed vector bench for control_sequencer
module tb_control_sequencer;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic [1:0] in_sel;
    logic [3:0] alu_op;
    logic [3:0] src_sel;
    logic [3:0] dst_sel;
    logic       in_en;
    logic       up_en;
    logic       lo_en;
    logic       pc_inc;
    logic       sp_inc;
    logic       sp_dec;
    logic       out_en;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [15:0] instr;
    out_t        exec_exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec;
  logic        out_en, halted, illegal;
  logic [1:0]  mem_addr_sel, in_sel;
  logic [3:0]  alu_op, src_sel, dst_sel;

  int total = 0;
  int bad = 0;

  control_sequencer dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .in_sel(in_sel), .alu_op(alu_op), .src_sel(src_sel), .dst_sel(dst_sel),
    .in_en(in_en), .up_en(up_en), .lo_en(lo_en), .pc_inc(pc_inc),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .out_en(out_en), .halted(halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic out_t rs(input logic [3:0] s, input logic [3:0] d);
    out_t o;
    o = '0;
    o.src_sel = s;
    o.dst_sel = d;
    return o;
  endfunction

  function automatic out_t fetch_exp(input logic ack);
    out_t o;
    o = '0;
    o.mem_req = 1'b1;
    o.pc_inc  = ack;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input out_t e);
    out_t a;
    #1;
    a = '{mem_req, mem_we, mem_addr_sel, in_sel, alu_op, src_sel, dst_sel,
          in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, out_en, halted, illegal};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Current state is FETCH; ack immediately, then check DECODE and leave at EXEC.
  task automatic fetch_decode(input string nm, input logic [15:0] instr);
    mem_rdata = instr;
    mem_ack   = 1'b1;
    chk({nm, "_fetch"}, fetch_exp(1'b1));
    tick();
    mem_rdata = 16'hDEAD;
    chk({nm, "_decode"}, rs(instr[7:4], instr[11:8]));
    tick();
  endtask

  vec_t vecs[9];
  out_t e;

  initial begin
    vecs[0].instr = 16'h2312; vecs[0].exec_exp = rs(4'h1, 4'h3);
    vecs[0].exec_exp.in_sel = 2'd1; vecs[0].exec_exp.lo_en = 1'b1;
    vecs[1].instr = 16'h0AB0; vecs[1].exec_exp = rs(4'hB, 4'hA);
    vecs[2].instr = 16'h1450; vecs[2].exec_exp = rs(4'h5, 4'h4);
    vecs[2].exec_exp.in_en = 1'b1;
    vecs[3].instr = 16'h3212; vecs[3].exec_exp = rs(4'h1, 4'h2);
    vecs[3].exec_exp.in_sel = 2'd1; vecs[3].exec_exp.up_en = 1'b1;
    vecs[4].instr = 16'h8345; vecs[4].exec_exp = rs(4'h4, 4'h3);
    vecs[4].exec_exp.in_sel = 2'd3; vecs[4].exec_exp.in_en = 1'b1;
    vecs[4].exec_exp.alu_op = 4'h5;
    vecs[5].instr = 16'h9070; vecs[5].exec_exp = rs(4'h7, 4'h1);
    vecs[5].exec_exp.in_en = 1'b1;
    vecs[6].instr = 16'hB000; vecs[6].exec_exp = rs(4'h0, 4'h0);
    vecs[6].exec_exp.illegal = 1'b1;
    vecs[7].instr = 16'hE123; vecs[7].exec_exp = rs(4'h2, 4'h1);
    vecs[7].exec_exp.illegal = 1'b1;
    vecs[8].instr = 16'h2012; vecs[8].exec_exp = rs(4'h1, 4'h0);
    vecs[8].exec_exp.in_sel = 2'd1; vecs[8].exec_exp.lo_en = 1'b1;

    mem_ack = 1'b1;
    #2;
    chk("reset_outputs", '0);
    @(negedge clk);
    rst = 1'b0;
    chk("idle_ignores_ack", '0);
    tick();

    // Register ops: each EXEC is followed directly by the next FETCH.
    for (int i = 0; i < 9; i++) begin
      fetch_decode($sformatf("v%0d", i), vecs[i].instr);
      chk($sformatf("v%0d_exec", i), vecs[i].exec_exp);
      tick();
    end

    // FETCH wait state holds the request without pc_inc.
    mem_ack = 1'b0;
    chk("fetch_wait", fetch_exp(1'b0));
    tick();

    // PUSH with three wait states in MEM.
    fetch_decode("push", 16'h6050);
    chk("push_exec", rs(4'h5, 4'h0));
    tick();
    mem_ack = 1'b0;
    e = rs(4'h5, 4'h0);
    e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 2'd3; e.out_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("push_wait%0d", w), e);
      tick();
    end
    mem_ack = 1'b1;
    e.sp_dec = 1'b1;
    chk("push_ack", e);
    tick();

    fetch_decode("pop", 16'h7500);
    e = rs(4'h0, 4'h5); e.sp_inc = 1'b1;
    chk("pop_exec", e);
    tick();
    e = rs(4'h0, 4'h5);
    e.mem_req = 1'b1; e.addr_sel = 2'd3; e.in_sel = 2'd2; e.in_en = 1'b1;
    chk("pop_ack", e);
    tick();

    fetch_decode("load", 16'h4380);
    chk("load_exec", rs(4'h8, 4'h3));
    tick();
    e = rs(4'h8, 4'h3);
    e.mem_req = 1'b1; e.addr_sel = 2'd1; e.in_sel = 2'd2; e.in_en = 1'b1;
    chk("load_ack", e);
    tick();

    fetch_decode("store", 16'h5630);
    chk("store_exec", rs(4'h3, 4'h6));
    tick();
    e = rs(4'h3, 4'h6);
    e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 2'd2; e.out_en = 1'b1;
    chk("store_ack", e);
    tick();

    // Reset in the middle of a LOAD memory wait.
    fetch_decode("rload", 16'h4120);
    chk("rload_exec", rs(4'h2, 4'h1));
    tick();
    mem_ack = 1'b0;
    e = rs(4'h2, 4'h1); e.mem_req = 1'b1; e.addr_sel = 2'd1;
    chk("rload_wait", e);
    #2;
    rst = 1'b1;
    chk("rst_mid_outputs", '0);
    total++;
    if (dut.ir_q !== 16'h0000) begin
      bad++;
      $display("FAIL rst_mid_ir: got %h want 0000", dut.ir_q);
    end
    @(negedge clk);
    rst = 1'b0;
    chk("rst_idle", '0);
    tick();
    chk("rst_fetch", fetch_exp(1'b0));

    // HALT is terminal; ack toggling must not wake it.
    fetch_decode("halt", 16'hF000);
    chk("halt_exec", '0);
    e = '0; e.halted = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      mem_ack = c[0];
      chk($sformatf("halted%0d", c), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the tiny16 core.
- Sits directly upstream of the 16-entry register file and drives all of its control inputs: select lines, write enables, PC/SP increment and decrement.
- Also drives the memory request handshake and the datapath input-mux select.
- One instruction in flight; no pipelining.

Parameters:
- PC_IDX, 4'd1, register index of program counter.
- SP_IDX, 4'd2, register index of stack pointer.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rdata  in  16  memory read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  memory completes the current request (sampled while mem_req=1).
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  write request (1) or read request (0); valid with mem_req.
- mem_addr_sel  out  2  memory address source: 0=PC, 1=src, 2=dst, 3=SP.
- in_sel  out  2  register-file input mux: 0=src, 1=imm8 zero-extended, 2=mem_rdata, 3=alu result.
- alu_op  out  4  equals ir[3:0] during ALU execute; 0 otherwise.
- src_sel  out  4  register-file source select.
- dst_sel  out  4  register-file destination select.
- in_en  out  1  full-word register write.
- up_en  out  1  upper-byte write.
- lo_en  out  1  lower-byte write.
- pc_inc  out  1  PC increment.
- sp_inc  out  1  SP increment.
- sp_dec  out  1  SP decrement.
- out_en  out  1  register-file output enable (store data phases).
- halted  out  1  core halted.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:

Instruction format:
- ir[15:12] = opcode, ir[11:8] = D, ir[7:4] = S, ir[7:0] = imm8.
- ir is a 16-bit register, reset to 0.

States and transitions:
- IDLE → FETCH → DECODE → EXEC → (MEM) → FETCH; HALT is terminal.
- State register resets to IDLE. IDLE always moves to FETCH on the next clock.
- All outputs are 0 in IDLE, and therefore 0 throughout reset.

FETCH:
- mem_req=1, mem_we=0, mem_addr_sel=0.
- Wait while mem_ack=0.
- In the ack cycle: ir<=mem_rdata, pc_inc=1, next state DECODE.

DECODE:
- src_sel=S, dst_sel=D, no enables asserted.
- Next state EXEC.

EXEC (src_sel=S, dst_sel=D unless stated otherwise):
- 0 NOP: no enables; → FETCH.
- 1 MOV: in_sel=0, in_en=1; → FETCH.
- 2 LDL: in_sel=1, lo_en=1; → FETCH.
- 3 LDH: in_sel=1, up_en=1; → FETCH.
- 4 LOAD: → MEM.
- 5 STORE: → MEM.
- 6 PUSH: → MEM.
- 7 POP: sp_inc=1; → MEM.
- 8 ALU: in_sel=3, in_en=1, alu_op=ir[3:0]; → FETCH.
- 9 JMP: dst_sel=PC_IDX, in_sel=0, in_en=1; → FETCH.
- F HALT: → HALT.
- A–E: illegal=1 for one cycle, otherwise treated as NOP; → FETCH.

MEM (mem_req held until mem_ack):
- LOAD: addr_sel=1, we=0. On ack: in_sel=2, in_en=1.
- STORE: addr_sel=2, we=1, out_en=1.
- PUSH: addr_sel=3, we=1, out_en=1. On ack: sp_dec=1.
- POP: addr_sel=3, we=0, addr is the already-incremented SP. On ack: in_sel=2, in_en=1.
- All MEM cases → FETCH after ack.

HALT:
- halted=1; all other outputs 0.
- Exit only via rst.

Invariants:
- Never assert sp_inc and sp_dec in the same cycle.
- Never assert pc_inc in a cycle where in_en targets PC_IDX.
- At most one of in_en, up_en, lo_en is asserted per cycle.

Boundary conditions:
- Writes with D=0 are issued as decoded; the register file discards them.
- mem_ack while mem_req=0 is ignored.
- Unbounded wait states are allowed; outputs stay stable while waiting.
- rst mid-instruction: immediate return to IDLE, ir cleared, no enable pulses.

Latency with zero-wait memory (ack in the first request cycle):
- Register ops: 3 cycles each.
- Memory ops: 4 cycles each.

Test Plan:
- Reset, then mem_ack tied to 1 with mem_rdata=16'h2312 → FETCH pulses pc_inc; EXEC drives dst_sel=3, in_sel=1, lo_en=1 exactly one cycle; next FETCH is 3 cycles after the first.
- PUSH (16'h6050) with ack delayed 3 cycles in MEM → mem_req/mem_we/out_en held 4 cycles, mem_addr_sel=3; sp_dec pulses only in the ack cycle.
- POP (16'h7500) → sp_inc in EXEC; MEM read at addr_sel=3; in the ack cycle in_sel=2, dst_sel=5, in_en=1; never sp_inc and sp_dec together.
- JMP (16'h9070) → EXEC drives dst_sel=1, src_sel=7, in_en=1, pc_inc=0; next fetch uses the new PC.
- Opcode 16'hB000 → illegal pulses exactly one cycle, no enables, returns to FETCH; opcode 16'hF000 → halted=1 and stays high for 20 cycles with mem_req=0.
- Assert rst during a LOAD MEM wait → all outputs 0 immediately, ir=0; after release, IDLE then FETCH with mem_addr_sel=0.
